safe_seq_detector: RTL and testbench
====================================

# safe_seq_detector

Parametrised safe sequence-detector FSM: matches a configurable pattern of PAT_LEN symbols of DATA_W bits on a qualified input stream, with optional overlapping matches, and recovers from illegal state codes. Every unused state code returns to S0, raises a sticky flag and increments a saturating error counter. The block sits next to the control FSMs in the datapath as a reusable detector, and includes a state-injection port so benches can exercise illegal-state recovery.

## Interface
- DATA_W, 1: symbol width, ≥1.
- PAT_LEN, 4: pattern length in symbols, ≥1.
- PATTERN, 'b1011: PAT_LEN*DATA_W bits. The first symbol is the most significant DATA_W bits: P[0] = PATTERN[PAT_LEN*DATA_W-1 -: DATA_W].
- OVERLAP, 1: 1 = overlapping matches (KMP-style fallback); 0 = restart after a match or mismatch.
- ERR_CNT_W, 8: error counter width.
- STATE_W (localparam): max(1, clog2(PAT_LEN+1)). Codes 0..PAT_LEN-1 are legal. Codes ≥PAT_LEN are illegal.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  DATA_W  input symbol.
- data_valid  in  1  symbol qualifier.
- clear_err  in  1  clears illegal and err_count.
- inject_en  in  1  test only: load inject_val into the state register.
- inject_val  in  STATE_W  value to inject.
- match  out  1  registered one-cycle pulse per detected pattern.
- state_out  out  STATE_W  current state register (number of pattern symbols matched).
- illegal  out  1  sticky illegal-state flag.
- err_count  out  ERR_CNT_W  saturating count of illegal-state recoveries.

## Operation
- State k (0..PAT_LEN-1) means the last k accepted symbols equal P[0..k-1].
- Edge priority, highest first:
  - reset.
  - inject_en: state ← inject_val, match ← 0.
  - Illegal state (state ≥ PAT_LEN): state ← 0, match ← 0, illegal ← 1, err_count ← err_count+1, saturating at all-ones.
  - data_valid = 0: state holds, match ← 0.
  - data_valid = 1: transitions below.
- Transitions in state k with symbol s:
  - s == P[k] and k < PAT_LEN-1: state ← k+1, match ← 0.
  - s == P[PAT_LEN-1] and k == PAT_LEN-1: match ← 1. State ← F(PAT_LEN) if OVERLAP=1, else 0.
  - Mismatch, OVERLAP=1: state ← δ(k,s), the longest proper prefix of P[0..k-1]·s that is also a suffix of it. This is the KMP automaton, computed at elaboration time.
  - Mismatch, OVERLAP=0: state ← (s == P[0]) ? 1 : 0.
  - F(n) is the length of the longest proper border of P[0..n-1].
- PAT_LEN = 1: state stays 0, and match pulses for every valid symbol equal to P[0].
- The illegal check runs regardless of data_valid. The symbol presented on the recovery edge is discarded.
- clear_err at an edge: illegal ← 0, err_count ← 0.
- clear_err on the same edge as an illegal detection: detection wins, so illegal = 1 and err_count = 1.
- err_count saturates and does not wrap. illegal stays set until clear_err or reset.
- inject_val may be any value. A legal injected value simply loads. An illegal one is caught on the next edge.

## Timing
- Reset values: state_out = 0, match = 0, illegal = 0, err_count = 0, applied immediately on reset assertion (asynchronous).
- Deassertion is synchronous to clk. The first symbol is accepted on the first rising edge with reset low.
- Match latency: match is high in the cycle after the edge that sampled the final pattern symbol, and lasts exactly one cycle.
- Back-to-back matches with OVERLAP=1 produce consecutive pulses when the pattern allows it (e.g. an all-same-symbol pattern).
- Illegal recovery: one edge after the illegal code appears, state_out = 0 and illegal = 1. err_count updates on the same edge.
- Reset mid-pattern: state and match clear, partial progress is lost, and the counters clear.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Defaults, OVERLAP=1, stream 1,0,1,1,0,1,1 all valid -> match pulses after the 4th and 7th symbols. state_out sequence 1,2,3,1,2,3,1.
- OVERLAP=0, same stream -> exactly one pulse, after the 4th symbol. state_out ends at 1.
- Defaults, stream 1,0 then data_valid=0 for 5 cycles then 1,1 -> state holds at 2 during the gap, and one match pulse follows the final 1.
- inject_en with inject_val=6 -> next edge state_out=6. Following edge state_out=0, illegal=1, err_count=1. Repeat 300 times with ERR_CNT_W=8 -> err_count saturates at 255.
- Illegal detection with clear_err asserted on the same edge -> illegal=1, err_count=1. Then clear_err alone -> illegal=0, err_count=0.
- DATA_W=2, PAT_LEN=3, PATTERN=6'b11_00_11, stream 3,0,3,0,3 -> matches after the 3rd and 5th symbols. Assert reset after the 4th symbol -> all outputs 0 at once and no further match.

Source files
------------

// File: rtl/safe_seq_detector_if.sv
// safe_seq_detector_if: symbol stream, test controls and status outputs of the sequence detector
interface safe_seq_detector_if #(
  parameter int DATA_W = 1,
  parameter int STATE_W = 3,
  parameter int ERR_CNT_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic data_valid;
  logic clear_err;
  logic inject_en;
  logic [STATE_W-1:0] inject_val;
  logic match;
  logic [STATE_W-1:0] state_out;
  logic illegal;
  logic [ERR_CNT_W-1:0] err_count;
  modport master (
    output data_in, data_valid, clear_err, inject_en, inject_val,
    input match, state_out, illegal, err_count
  );
  modport slave (
    input data_in, data_valid, clear_err, inject_en, inject_val,
    output match, state_out, illegal, err_count
  );
endinterface

// File: rtl/safe_seq_detector.sv
// safe_seq_detector: KMP/restart pattern detector with illegal-state recovery and error counting
module safe_seq_detector #(
  parameter int DATA_W = 1,
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN*DATA_W-1:0] PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic reset,
  safe_seq_detector_if.slave bus
);
  localparam int STATE_W = $clog2(PAT_LEN + 1);
  typedef logic [STATE_W-1:0] st_t;
  function automatic logic [DATA_W-1:0] sym(int i);
    return PATTERN[(PAT_LEN-1-i)*DATA_W +: DATA_W];
  endfunction
  // bit k*PAT_LEN+m: P[0..m-1] is a suffix of P[0..k-1]
  function automatic logic [PAT_LEN*PAT_LEN-1:0] borders();
    logic [PAT_LEN*PAT_LEN-1:0] b;
    b = '0;
    for (int k = 0; k < PAT_LEN; k++)
      for (int m = 0; m <= k; m++) begin
        b[k*PAT_LEN+m] = 1'b1;
        for (int i = 0; i < m; i++)
          if (sym(i) != sym(k-m+i)) b[k*PAT_LEN+m] = 1'b0;
      end
    return b;
  endfunction
  function automatic int border_len();
    int f;
    f = 0;
    for (int m = 1; m < PAT_LEN; m++) begin
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < m; i++)
        if (sym(i) != sym(PAT_LEN-m+i)) ok = 1'b0;
      if (ok) f = m;
    end
    return f;
  endfunction
  localparam logic [PAT_LEN*PAT_LEN-1:0] BORD = borders();
  localparam st_t FB = st_t'(border_len());
  st_t state, nstate, dlt;
  logic hit, nhit, ill, nill, bad, last;
  logic [DATA_W-1:0] pk;
  logic [ERR_CNT_W-1:0] cnt, ncnt;
  always_comb begin
    pk = '0;
    dlt = '0;
    for (int k = 0; k < PAT_LEN; k++)
      if (state == st_t'(k)) begin
        pk = sym(k);
        for (int j = 1; j <= k; j++)
          if (BORD[k*PAT_LEN+j-1] && sym(j-1) == bus.data_in) dlt = st_t'(j);
      end
    bad = {1'b0, state} >= (STATE_W+1)'(PAT_LEN);
    last = state == st_t'(PAT_LEN - 1);
    nstate = state;
    nhit = 1'b0;
    nill = bus.clear_err ? 1'b0 : ill;
    ncnt = bus.clear_err ? '0 : cnt;
    if (bus.inject_en) nstate = bus.inject_val;
    else if (bad) begin
      nstate = '0;
      nill = 1'b1;
      ncnt = &ncnt ? ncnt : ncnt + 1'b1;
    end else if (bus.data_valid) begin
      if (bus.data_in == pk) begin
        nhit = last;
        nstate = last ? (OVERLAP ? FB : '0) : state + 1'b1;
      end else nstate = OVERLAP ? dlt : st_t'(bus.data_in == sym(0));
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= '0;
      hit <= 1'b0;
      ill <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nstate;
      hit <= nhit;
      ill <= nill;
      cnt <= ncnt;
    end
  assign bus.state_out = state;
  assign bus.match = hit;
  assign bus.illegal = ill;
  assign bus.err_count = cnt;
endmodule

// File: tb/tb_safe_seq_detector.sv
// tb_safe_seq_detector: three detector configurations checked against a history-based reference model
module tb_safe_seq_detector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  safe_seq_detector_if #(.DATA_W(1), .STATE_W(3), .ERR_CNT_W(8)) ia();
  safe_seq_detector_if #(.DATA_W(1), .STATE_W(3), .ERR_CNT_W(8)) ib();
  safe_seq_detector_if #(.DATA_W(2), .STATE_W(2), .ERR_CNT_W(8)) ic();
  safe_seq_detector u_a (.clk(clk), .reset(reset), .bus(ia));
  safe_seq_detector #(.OVERLAP(1'b0)) u_b (.clk(clk), .reset(reset), .bus(ib));
  safe_seq_detector #(.DATA_W(2), .PAT_LEN(3), .PATTERN(6'b11_00_11)) u_c (.clk(clk), .reset(reset), .bus(ic));
  int checks = 0;
  int errors = 0;
  int est[3], em[3], eill[3], ecnt[3], plen[3], ovl[3];
  int pat[3][4];
  int hist[3][$];
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  // longest j <= lim such that the last j accepted symbols spell P[0..j-1]
  function automatic int longest(int d, int lim);
    int n, best;
    n = hist[d].size();
    best = 0;
    for (int j = 1; j <= lim && j <= n; j++) begin
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < j; i++) if (hist[d][n-j+i] != pat[d][i]) ok = 1'b0;
      if (ok) best = j;
    end
    return best;
  endfunction
  task automatic step(input int d, input bit v, input int s, input bit clr, input bit inj, input int iv);
    em[d] = 0;
    if (clr) begin
      eill[d] = 0;
      ecnt[d] = 0;
    end
    if (inj) begin
      est[d] = iv;
      hist[d].delete();
      if (iv < plen[d]) for (int i = 0; i < iv; i++) hist[d].push_back(pat[d][i]);
    end else if (est[d] >= plen[d]) begin
      est[d] = 0;
      hist[d].delete();
      eill[d] = 1;
      ecnt[d] = ecnt[d] == 255 ? 255 : ecnt[d] + 1;
    end else if (v) begin
      if (ovl[d] != 0) begin
        hist[d].push_back(s);
        if (hist[d].size() > plen[d]) void'(hist[d].pop_front());
        em[d] = longest(d, plen[d]) == plen[d] ? 1 : 0;
        est[d] = longest(d, plen[d] - 1);
      end else if (s == pat[d][est[d]]) begin
        em[d] = est[d] + 1 == plen[d] ? 1 : 0;
        est[d] = em[d] != 0 ? 0 : est[d] + 1;
      end else est[d] = s == pat[d][0] ? 1 : 0;
    end
  endtask
  task automatic compare();
    check("a_state", ia.state_out, est[0]);
    check("a_match", ia.match, em[0]);
    check("a_illegal", ia.illegal, eill[0]);
    check("a_errcnt", ia.err_count, ecnt[0]);
    check("b_state", ib.state_out, est[1]);
    check("b_match", ib.match, em[1]);
    check("b_illegal", ib.illegal, eill[1]);
    check("b_errcnt", ib.err_count, ecnt[1]);
    check("c_state", ic.state_out, est[2]);
    check("c_match", ic.match, em[2]);
    check("c_illegal", ic.illegal, eill[2]);
    check("c_errcnt", ic.err_count, ecnt[2]);
  endtask
  task automatic drive(input bit v, input int s, input bit clr, input bit inj, input int iv);
    ia.data_valid = v; ib.data_valid = v; ic.data_valid = v;
    ia.data_in = 1'(s); ib.data_in = 1'(s); ic.data_in = 2'(s);
    ia.clear_err = clr; ib.clear_err = clr; ic.clear_err = clr;
    ia.inject_en = inj; ib.inject_en = inj; ic.inject_en = inj;
    ia.inject_val = 3'(iv); ib.inject_val = 3'(iv); ic.inject_val = 2'(iv);
  endtask
  task automatic cycle(input bit v, input int s, input bit clr, input bit inj, input int iv);
    drive(v, s, clr, inj, iv);
    for (int d = 0; d < 3; d++) step(d, v, d == 2 ? s & 3 : s & 1, clr, inj, d == 2 ? iv & 3 : iv & 7);
    @(posedge clk);
    #1;
    compare();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      est[d] = 0; em[d] = 0; eill[d] = 0; ecnt[d] = 0;
      hist[d].delete();
    end
    compare();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    int sa[7];
    int s1[7];
    int s3[5];
    sa = '{1, 2, 3, 1, 2, 3, 1};
    s1 = '{1, 0, 1, 1, 0, 1, 1};
    s3 = '{3, 0, 3, 0, 3};
    plen = '{4, 4, 3};
    ovl = '{1, 0, 1};
    pat[0] = '{1, 0, 1, 1};
    pat[1] = '{1, 0, 1, 1};
    pat[2] = '{3, 0, 3, 0};
    drive(0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1, s1[i], 0, 0, 0);
      check("ovl_seq", ia.state_out, sa[i]);
      check("ovl_pulse", ia.match, (i == 3 || i == 6) ? 1 : 0);
      check("noovl_pulse", ib.match, i == 3 ? 1 : 0);
    end
    check("noovl_end", ib.state_out, 1);
    do_reset();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (5) begin
      cycle(0, $urandom, 0, 0, 0);
      check("gap_hold", ia.state_out, 2);
    end
    cycle(1, 1, 0, 0, 0);
    check("gap_nomatch", ia.match, 0);
    cycle(1, 1, 0, 0, 0);
    check("gap_match", ia.match, 1);
    cycle(0, 0, 0, 0, 0);
    check("pulse_once", ia.match, 0);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(0, 0, 0, 1, 6);
      if (i == 0) check("inj_load", ia.state_out, 6);
      cycle(0, 0, 0, 0, 0);
      if (i == 0) begin
        check("rec_state", ia.state_out, 0);
        check("rec_illegal", ia.illegal, 1);
        check("rec_cnt", ia.err_count, 1);
      end
    end
    check("sat_cnt", ia.err_count, 255);
    cycle(0, 0, 0, 1, 6);
    cycle(0, 0, 1, 0, 0);
    check("clr_race_ill", ia.illegal, 1);
    check("clr_race_cnt", ia.err_count, 1);
    cycle(0, 0, 1, 0, 0);
    check("clr_ill", ia.illegal, 0);
    check("clr_cnt", ia.err_count, 0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1, s3[i], 0, 0, 0);
      check("w2_pulse", ic.match, (i == 2 || i == 4) ? 1 : 0);
    end
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, s3[i], 0, 0, 0);
    reset = 1'b1;
    #1;
    check("async_state", ic.state_out, 0);
    check("async_match", ic.match, 0);
    do_reset();
    cycle(1, 3, 0, 0, 0);
    check("post_rst_match", ic.match, 0);
    check("post_rst_state", ic.state_out, 1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) do_reset();
      cycle($urandom_range(3) != 0, $urandom, $urandom_range(31) == 0, $urandom_range(15) == 0, $urandom_range(7));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
